// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA message-schedule datapath.
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WORD_W = 64;
  localparam int SHA512_ROUNDS = 80;

  localparam int SCHED_DEPTH   = 16;
  localparam int DEF_TAP_A     = 1;
  localparam int DEF_TAP_B     = 9;
  localparam int DEF_TAP_C     = 14;

endpackage

// File: rtl/sha_sched_window_if.sv
// Block-load handshake and round-advance bus between the compression core
// and the message-schedule window.
interface sha_sched_window_if
  import sha_pkg::*;
#(
  parameter int WORD_W = SHA256_WORD_W,
  parameter int DEPTH  = SCHED_DEPTH,
  parameter int ROUNDS = SHA256_ROUNDS
) ();

  localparam int RW = $clog2(ROUNDS);

  logic                      clr;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [WORD_W*DEPTH-1:0]   blk_data;
  logic                      adv;
  logic [WORD_W-1:0]         next_w;
  logic                      w_valid;
  logic [WORD_W-1:0]         w_out;
  logic [WORD_W-1:0]         tap_a;
  logic [WORD_W-1:0]         tap_b;
  logic [WORD_W-1:0]         tap_c;
  logic [RW-1:0]             round;
  logic                      done;

  modport master (
    output clr, blk_valid, blk_data, adv, next_w,
    input  blk_ready, w_valid, w_out, tap_a, tap_b, tap_c, round, done
  );

  modport slave (
    input  clr, blk_valid, blk_data, adv, next_w,
    output blk_ready, w_valid, w_out, tap_a, tap_b, tap_c, round, done
  );

endinterface

// File: rtl/sha_word_reg.sv
// One schedule-window word: loads from the message block or from the
// neighbouring shift source, otherwise holds.
module sha_word_reg #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic [WORD_W-1:0] shift_word_i,
  output logic [WORD_W-1:0] q_o
);

  logic [WORD_W-1:0] q_q;
  logic [WORD_W-1:0] q_d;

  // Load mux: a block load wins over a shift; the two never coincide anyway.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_word_i;
    end else if (shift_i) begin
      q_d = shift_word_i;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sha_sched_window.sv
// DEPTH-word sliding message-schedule window with a round counter; serves
// SHA-256 and SHA-512 depending on WORD_W/ROUNDS.
module sha_sched_window
  import sha_pkg::*;
#(
  parameter int WORD_W = SHA256_WORD_W,
  parameter int DEPTH  = SCHED_DEPTH,
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int TAP_A  = DEF_TAP_A,
  parameter int TAP_B  = DEF_TAP_B,
  parameter int TAP_C  = DEF_TAP_C
) (
  input  logic              CLK,
  input  logic              RST,
  sha_sched_window_if.slave sched_if
);

  localparam int            RW         = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  if ((TAP_A >= DEPTH) || (TAP_B >= DEPTH) || (TAP_C >= DEPTH)) begin : g_tap_chk
    $error("sha_sched_window: every tap index must be below DEPTH");
  end
  if (ROUNDS < DEPTH) begin : g_rounds_chk
    $error("sha_sched_window: ROUNDS must be at least DEPTH");
  end

  sched_state_t      state_q;
  sched_state_t      state_d;
  logic [RW-1:0]     round_q;
  logic [RW-1:0]     round_d;
  logic              load_s;
  logic              shift_s;
  logic [WORD_W-1:0] win_s [DEPTH];

  // clr outranks everything except RST and leaves the window untouched.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    load_s  = 1'b0;
    shift_s = 1'b0;
    if (sched_if.clr) begin
      state_d = IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sched_if.blk_valid) begin
            load_s  = 1'b1;
            round_d = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (sched_if.adv) begin
            shift_s = 1'b1;
            if (round_q == LAST_ROUND) begin
              round_d = '0;
              state_d = DONE;
            end else begin
              round_d = round_q + RW'(1);
            end
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Word i takes block word i (W0 in the MSBs) on load, its upper neighbour on shift.
  for (genvar i = 0; i < DEPTH; i++) begin : g_win
    logic [WORD_W-1:0] shift_src_s;
    if (i == DEPTH - 1) begin : g_tail
      assign shift_src_s = sched_if.next_w;
    end else begin : g_body
      assign shift_src_s = win_s[i+1];
    end

    sha_word_reg #(
      .WORD_W (WORD_W)
    ) u_word (
      .CLK          (CLK),
      .RST          (RST),
      .load_i       (load_s),
      .shift_i      (shift_s),
      .load_word_i  (sched_if.blk_data[WORD_W*(DEPTH-i)-1 -: WORD_W]),
      .shift_word_i (shift_src_s),
      .q_o          (win_s[i])
    );
  end

  assign sched_if.blk_ready = (state_q == IDLE);
  assign sched_if.w_valid   = (state_q == RUN);
  assign sched_if.done      = (state_q == DONE);
  assign sched_if.round     = round_q;
  assign sched_if.w_out     = win_s[0];
  assign sched_if.tap_a     = win_s[TAP_A];
  assign sched_if.tap_b     = win_s[TAP_B];
  assign sched_if.tap_c     = win_s[TAP_C];

endmodule

// File: tb/tb_sha_sched_window.sv
// Self-checking bench: SHA-256 instance against a stream/offset model, plus a
// SHA-512 instance checked with a counting pattern.
module tb_sha_sched_window;
  import sha_pkg::*;

  localparam int W  = SHA256_WORD_W;
  localparam int D  = SCHED_DEPTH;
  localparam int R  = SHA256_ROUNDS;
  localparam int W5 = SHA512_WORD_W;
  localparam int R5 = SHA512_ROUNDS;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sha_sched_window_if #(.WORD_W(W),  .DEPTH(D), .ROUNDS(R))  bus  ();
  sha_sched_window_if #(.WORD_W(W5), .DEPTH(D), .ROUNDS(R5)) bus5 ();

  sha_sched_window #(.WORD_W(W), .DEPTH(D), .ROUNDS(R),
                     .TAP_A(1), .TAP_B(9), .TAP_C(14))
    u_dut (.CLK(CLK), .RST(RST), .sched_if(bus));

  sha_sched_window #(.WORD_W(W5), .DEPTH(D), .ROUNDS(R5),
                     .TAP_A(1), .TAP_B(9), .TAP_C(14))
    u_dut5 (.CLK(CLK), .RST(RST), .sched_if(bus5));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference SHA-256 message schedule
  logic [31:0] abc [0:15];
  logic [31:0] tab [0:R+D-1];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Model: every word ever loaded/shifted in is kept in a stream; the window is an offset into it.
  int          m_phase;
  int          m_t;
  int          m_base;
  bit          m_zero;
  logic [31:0] strm [0:127];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase <= 0;
      m_t     <= 0;
      m_base  <= 0;
      m_zero  <= 1'b1;
    end else if (bus.clr) begin
      m_phase <= 0;
      m_t     <= 0;
    end else if (m_phase == 0) begin
      if (bus.blk_valid) begin
        for (int i = 0; i < D; i++) strm[i] <= bus.blk_data[32*(D-i)-1 -: 32];
        m_base  <= 0;
        m_zero  <= 1'b0;
        m_phase <= 1;
        m_t     <= 0;
      end
    end else if (m_phase == 1) begin
      if (bus.adv) begin
        strm[m_base+D] <= bus.next_w;
        m_base         <= m_base + 1;
        if (m_t == R - 1) begin
          m_t     <= 0;
          m_phase <= 2;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end else begin
      m_phase <= 0;
    end
  end

  function automatic logic [31:0] mwin(input int i);
    return m_zero ? 32'h0 : strm[m_base+i];
  endfunction

  always @(negedge CLK) begin
    if (chk_en && !RST) begin
      chk("blk_ready", 64'(bus.blk_ready), 64'(m_phase == 0));
      chk("w_valid",   64'(bus.w_valid),   64'(m_phase == 1));
      chk("done",      64'(bus.done),      64'(m_phase == 2));
      chk("round",     64'(bus.round),     64'(m_t));
      chk("w_out",     64'(bus.w_out),     64'(mwin(0)));
      chk("tap_a",     64'(bus.tap_a),     64'(mwin(1)));
      chk("tap_b",     64'(bus.tap_b),     64'(mwin(9)));
      chk("tap_c",     64'(bus.tap_c),     64'(mwin(14)));
    end
  end

  task automatic cycle(input logic v, input logic a, input logic c);
    @(negedge CLK);
    bus.blk_valid = v;
    bus.adv       = a;
    bus.clr       = c;
    bus.next_w    = (m_t + D < R + D) ? tab[m_t+D] : 32'h0;
  endtask

  int  ndone;
  int  n_adv;
  bit  seen;

  initial begin
    bus.clr = 1'b0; bus.blk_valid = 1'b0; bus.adv = 1'b0; bus.next_w = 32'h0;
    bus5.clr = 1'b0; bus5.blk_valid = 1'b0; bus5.adv = 1'b0; bus5.next_w = 64'h0;
    for (int i = 0; i < D; i++) abc[i] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    for (int t = 0; t < R + D; t++) begin
      if (t < D) tab[t] = abc[t];
      else tab[t] = sig1(tab[t-2]) + tab[t-7] + sig0(tab[t-15]) + tab[t-16];
    end
    for (int i = 0; i < D; i++) begin
      bus.blk_data[32*(D-i)-1 -: 32]  = abc[i];
      bus5.blk_data[64*(D-i)-1 -: 64] = 64'(i);
    end
    chk("tab_w16", 64'(tab[16]), 64'h61626380);
    chk("tab_w17", 64'(tab[17]), 64'h000F0000);

    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_ready",  64'(bus.blk_ready), 64'd1);
    chk("rst_wvalid", 64'(bus.w_valid),   64'd0);
    chk("rst_round",  64'(bus.round),     64'd0);
    chk("rst_done",   64'(bus.done),      64'd0);
    chk("rst_wout",   64'(bus.w_out),     64'd0);

    // abc block, adv held high
    cycle(1'b1, 1'b1, 1'b0);
    ndone = 0;
    for (int j = 0; j < 66; j++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (bus.done) ndone++;
      if (j == 0)  chk("abc_r0",  64'(bus.w_out), 64'h61626380);
      if (j == 15) chk("abc_r15", 64'(bus.w_out), 64'h00000018);
      if (j == 16) chk("abc_r16", 64'(bus.w_out), 64'h61626380);
      if (j == 17) chk("abc_r17", 64'(bus.w_out), 64'h000F0000);
      if (j == 64) chk("abc_done", 64'(bus.done), 64'd1);
      if (j == 65) chk("abc_ready_again", 64'(bus.blk_ready), 64'd1);
    end
    chk("abc_done_count", 64'(ndone), 64'd1);

    // 50% duty advance
    cycle(1'b1, 1'b0, 1'b0);
    n_adv = 0;
    seen  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, (k % 2) == 0, 1'b0);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if ((k % 2) == 0) n_adv++;
    end
    chk("stall_done_seen", 64'(seen), 64'd1);
    chk("stall_adv_count", 64'(n_adv), 64'd64);
    cycle(1'b0, 1'b0, 1'b0);

    // blk_valid held high across a whole block
    cycle(1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 67; j++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (j == 0 || j == 30) chk("hs_ready_run", 64'(bus.blk_ready), 64'd0);
      if (j == 64) begin
        chk("hs_ready_done", 64'(bus.blk_ready), 64'd0);
        chk("hs_done", 64'(bus.done), 64'd1);
      end
      if (j == 65) chk("hs_ready_idle", 64'(bus.blk_ready), 64'd1);
      if (j == 66) begin
        chk("hs_reload_valid", 64'(bus.w_valid), 64'd1);
        chk("hs_reload_round", 64'(bus.round), 64'd0);
      end
    end

    // clr together with adv at round 30
    for (int k = 1; k < 30; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("clr_pre_round", 64'(bus.round), 64'd30);
    cycle(1'b0, 1'b0, 1'b0);
    chk("clr_idle",  64'(bus.blk_ready), 64'd1);
    chk("clr_round", 64'(bus.round), 64'd0);
    chk("clr_hold",  64'(bus.w_out), 64'(tab[30]));
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("clr_no_done", 64'(bus.done), 64'd0);
    end

    // asynchronous reset at round 10
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("arst_pre_round", 64'(bus.round), 64'd10);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_ready",  64'(bus.blk_ready), 64'd1);
    chk("arst_wvalid", 64'(bus.w_valid),   64'd0);
    chk("arst_done",   64'(bus.done),      64'd0);
    chk("arst_round",  64'(bus.round),     64'd0);
    chk("arst_wout",   64'(bus.w_out),     64'd0);
    chk("arst_tapc",   64'(bus.tap_c),     64'd0);
    #1 RST = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // SHA-512 counting pattern
    @(negedge CLK);
    bus5.blk_valid = 1'b1;
    ndone = 0;
    for (int j = 0; j < 82; j++) begin
      @(negedge CLK);
      bus5.blk_valid = 1'b0;
      bus5.adv       = 1'b1;
      bus5.next_w    = 64'(j + D);
      if (bus5.done) ndone++;
      if (j < R5) begin
        chk("s512_round", 64'(bus5.round), 64'(j));
        chk("s512_wout",  bus5.w_out, 64'(j));
        chk("s512_tapa",  bus5.tap_a, 64'(j + 1));
        chk("s512_tapb",  bus5.tap_b, 64'(j + 9));
        chk("s512_tapc",  bus5.tap_c, 64'(j + 14));
      end
      if (j == R5)     chk("s512_done",  64'(bus5.done), 64'd1);
      if (j == R5 + 1) chk("s512_ready", 64'(bus5.blk_ready), 64'd1);
    end
    chk("s512_done_count", 64'(ndone), 64'd1);
    bus5.adv = 1'b0;

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
